// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: fetch/issue/writeback sequencer for a 16-bit ALU; define SEQ_ZERO_REG_EN to hardwire r0 to zero
module alu_seq_ctrl #(
  parameter int PC_W   = 8,
  parameter int NREG_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PC_W-1:0]   pc,
  output logic              instr_req,
  input  logic              instr_valid,
  input  logic [15:0]       instr_data,
  output logic [4:0]        alu_f,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic              alu_cin,
  input  logic [15:0]       alu_result,
  input  logic [5:0]        alu_status,
  output logic [5:0]        flags,
  input  logic              host_we,
  input  logic [NREG_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  output logic [15:0]       host_rdata
);
`ifdef SEQ_ZERO_REG_EN
  localparam logic ZR = 1'b1;
`else
  localparam logic ZR = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
  state_t state_q, state_d;
  logic [15:0] rf_q [2**NREG_W];
  logic [PC_W-1:0] pc_q;
  logic busy_q, done_q, err_q, alu_cin_q, wb_en_q, halt_q;
  logic [4:0] alu_f_q;
  logic [15:0] alu_a_q, alu_b_q, res_q;
  logic [5:0] stat_q, flags_q;
  logic [NREG_W-1:0] rd_q;
  logic legal, host_wr, wb_wr;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign pc         = pc_q;
  assign instr_req  = state_q == FETCH;
  assign alu_f      = alu_f_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign flags      = flags_q;
  assign host_rdata = rf_q[host_addr];
  // next state plus legality and register-file write enables; r0 is never written when hardwired
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? FETCH : IDLE;
      FETCH:   state_d = instr_valid ? EXEC : FETCH;
      EXEC:    state_d = WB;
      WB:      state_d = halt_q ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
    legal   = alu_f_q == 5'h01 || alu_f_q == 5'h03 || (alu_f_q >= 5'h04 && alu_f_q <= 5'h0B) || (alu_f_q >= 5'h10 && alu_f_q <= 5'h17);
    host_wr = state_q == IDLE && host_we && !(ZR && host_addr == '0);
    wb_wr   = state_q == WB && legal && wb_en_q && !(ZR && rd_q == '0);
  end
  // state register, issue/capture/writeback datapath and register file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      alu_f_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_cin_q <= 1'b0;
      flags_q   <= '0;
      res_q     <= '0;
      stat_q    <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      halt_q    <= 1'b0;
      for (int i = 0; i < 2**NREG_W; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (state_q == IDLE && start) begin
        pc_q   <= '0;
        err_q  <= 1'b0;
        busy_q <= 1'b1;
      end
      if (host_wr) rf_q[host_addr] <= host_wdata;
      if (state_q == FETCH && instr_valid) begin
        alu_f_q   <= instr_data[15:11];
        rd_q      <= instr_data[10:8];
        alu_a_q   <= rf_q[instr_data[7:5]];
        alu_b_q   <= rf_q[instr_data[4:2]];
        wb_en_q   <= instr_data[1];
        halt_q    <= instr_data[0];
        alu_cin_q <= flags_q[5];
      end
      if (state_q == EXEC) begin
        res_q  <= alu_result;
        stat_q <= alu_status;
      end
      if (state_q == WB) begin
        pc_q <= pc_q + 1'b1;
        if (legal) flags_q <= stat_q;
        else err_q <= 1'b1;
        if (wb_wr) rf_q[rd_q] <= res_q;
        if (halt_q) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl with a behavioural ALU and program store
module tb_alu_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, err, instr_req, instr_valid, alu_cin, host_we = 1'b0;
  logic [7:0] pc;
  logic [15:0] instr_data, alu_a, alu_b, alu_result, host_wdata = '0, host_rdata;
  logic [4:0] alu_f;
  logic [5:0] alu_status, flags;
  logic [2:0] host_addr = '0;
  logic [15:0] prog [256];
  logic [16:0] sum;
  logic hold = 1'b0;
  int checks = 0, errors = 0;
  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err), .pc(pc),
    .instr_req(instr_req), .instr_valid(instr_valid), .instr_data(instr_data),
    .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_status(alu_status), .flags(flags),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata)
  );
  always #5 clk = ~clk;
  assign instr_data  = prog[pc];
  assign instr_valid = instr_req && !hold;
  always_comb begin
    sum        = {1'b0, alu_a} + {1'b0, alu_b} + {16'b0, alu_f == 5'h05 && alu_cin};
    alu_result = (alu_f == 5'h04 || alu_f == 5'h05) ? sum[15:0] : (alu_a & alu_b);
    alu_status = {sum[16], alu_result == 16'h0, alu_result[15], alu_a[15] == alu_b[15] && sum[15] != alu_a[15], 2'b00};
  end
  task automatic host_write(input logic [2:0] a, input logic [15:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask
  task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
    host_addr = a;
    #1 d = host_rdata;
  endtask
  task automatic run_prog(output int dones, output logic to);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; dones = 0; to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (!busy) begin to = 1'b0; break; end
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_ctl got busy=%b done=%b err=%b exp 0 0 0", busy, done, err); end
    checks++; if (instr_req !== 1'b0 || pc !== 8'h00) begin errors++; $display("FAIL reset_fetch got req=%b pc=%h exp 0 00", instr_req, pc); end
    checks++; if ({alu_f, alu_a, alu_b, alu_cin, flags} !== '0) begin errors++; $display("FAIL reset_alu got f=%h a=%h b=%h cin=%b flags=%h exp all 0", alu_f, alu_a, alu_b, alu_cin, flags); end
  endtask
  task automatic test_add_halt;
    int dones; logic to; logic [15:0] r;
    host_write(3'd1, 16'h7FFF);
    host_write(3'd2, 16'h0001);
    prog[0] = 16'h232B;
    run_prog(dones, to);
    checks++; if (to) begin errors++; $display("FAIL add_timeout got busy=%b exp 0", busy); end
    read_reg(3'd3, r);
    checks++; if (r !== 16'h8000) begin errors++; $display("FAIL add_r3 got %h exp 8000", r); end
    checks++; if (flags !== 6'h0C) begin errors++; $display("FAIL add_flags got %h exp 0c", flags); end
    checks++; if (dones !== 1 || pc !== 8'h01) begin errors++; $display("FAIL add_done_pc got dones=%0d pc=%h exp 1 01", dones, pc); end
    checks++; if (alu_f !== 5'h04 || alu_a !== 16'h7FFF || alu_b !== 16'h0001 || alu_cin !== 1'b0) begin errors++; $display("FAIL add_issue got f=%h a=%h b=%h cin=%b exp 04 7fff 0001 0", alu_f, alu_a, alu_b, alu_cin); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_pulse got done=%b busy=%b exp 0 0", done, busy); end
  endtask
  task automatic test_carry_chain;
    int dones; logic to; logic [15:0] r;
    host_write(3'd1, 16'hFFFF);
    host_write(3'd2, 16'h0001);
    prog[0] = 16'h232A;
    prog[1] = 16'h2C4B;
    run_prog(dones, to);
    checks++; if (to || dones !== 1) begin errors++; $display("FAIL carry_run got to=%b dones=%0d exp 0 1", to, dones); end
    read_reg(3'd3, r);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL carry_r3 got %h exp 0000", r); end
    read_reg(3'd4, r);
    checks++; if (r !== 16'h0003) begin errors++; $display("FAIL carry_r4 got %h exp 0003", r); end
    checks++; if (alu_cin !== 1'b1 || alu_f !== 5'h05) begin errors++; $display("FAIL carry_cin got cin=%b f=%h exp 1 05", alu_cin, alu_f); end
    checks++; if (flags !== 6'h00 || pc !== 8'h02) begin errors++; $display("FAIL carry_final got flags=%h pc=%h exp 00 02", flags, pc); end
  endtask
  task automatic test_fetch_stall;
    int dones; logic to; logic [15:0] r;
    prog[0] = 16'h232B;
    hold = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_req !== 1'b1 || alu_f !== 5'h05 || alu_a !== 16'h0001 || pc !== 8'h00) begin errors++; $display("FAIL stall_hold%0d got req=%b f=%h a=%h pc=%h exp 1 05 0001 00", i, instr_req, alu_f, alu_a, pc); end
      @(negedge clk);
    end
    hold = 1'b0;
    @(negedge clk);
    checks++; if (instr_req !== 1'b0 || alu_f !== 5'h04 || alu_a !== 16'hFFFF) begin errors++; $display("FAIL stall_issue got req=%b f=%h a=%h exp 0 04 ffff", instr_req, alu_f, alu_a); end
    dones = 0; to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (!busy) begin to = 1'b0; break; end
    end
    read_reg(3'd3, r);
    checks++; if (to || dones !== 1 || r !== 16'h0000 || flags !== 6'h30) begin errors++; $display("FAIL stall_result got to=%b dones=%0d r3=%h flags=%h exp 0 1 0000 30", to, dones, r, flags); end
  endtask
  task automatic test_illegal;
    int dones; logic to; logic [15:0] r, exp_r0;
`ifdef SEQ_ZERO_REG_EN
    exp_r0 = 16'h0000;
`else
    exp_r0 = 16'h5555;
`endif
    host_write(3'd0, 16'h5555);
    prog[0] = 16'h0003;
    run_prog(dones, to);
    checks++; if (to || dones !== 1 || err !== 1'b1) begin errors++; $display("FAIL illegal_err got to=%b dones=%0d err=%b exp 0 1 1", to, dones, err); end
    read_reg(3'd0, r);
    checks++; if (flags !== 6'h30 || r !== exp_r0) begin errors++; $display("FAIL illegal_nowrite got flags=%h r0=%h exp 30 %h", flags, r, exp_r0); end
    prog[0] = 16'h232B;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL illegal_clear got err=%b busy=%b exp 0 1", err, busy); end
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
    end
    checks++; if (to || err !== 1'b0) begin errors++; $display("FAIL illegal_rerun got to=%b err=%b exp 0 0", to, err); end
  endtask
  task automatic test_pc_wrap;
    logic to;
    for (int i = 0; i < 256; i++) prog[i] = 16'h2328;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (pc == 8'hFF) begin to = 1'b0; break; end
    end
    checks++; if (to) begin errors++; $display("FAIL wrap_reach_ff got pc=%h exp ff", pc); end
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pc == 8'h00) begin to = 1'b0; break; end
    end
    checks++; if (to || busy !== 1'b1) begin errors++; $display("FAIL wrap_to_zero got pc=%h busy=%b exp 00 1", pc, busy); end
    prog[1] = 16'h2329;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
    end
    checks++; if (to || pc !== 8'h02 || done !== 1'b1) begin errors++; $display("FAIL wrap_halt got to=%b pc=%h done=%b exp 0 02 1", to, pc, done); end
  endtask
  task automatic test_reset_mid;
    logic [15:0] r;
    prog[0] = 16'h232B;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || instr_req !== 1'b0 || alu_f !== 5'h04) begin errors++; $display("FAIL midrst_exec got busy=%b req=%b f=%h exp 1 0 04", busy, instr_req, alu_f); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    read_reg(3'd3, r);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || instr_req !== 1'b0 || flags !== 6'h00 || r !== 16'h0000 || pc !== 8'h00) begin errors++; $display("FAIL midrst_state got busy=%b done=%b req=%b flags=%h r3=%h pc=%h exp 0 0 0 00 0000 00", busy, done, instr_req, flags, r, pc); end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || r !== host_rdata) begin errors++; $display("FAIL midrst_quiet got done=%b busy=%b r3=%h exp 0 0 0000", done, busy, host_rdata); end
  endtask
  task automatic test_zero_reg;
    int dones; logic to; logic [15:0] r, exp_host, exp_add;
`ifdef SEQ_ZERO_REG_EN
    exp_host = 16'h0000; exp_add = 16'h0000;
`else
    exp_host = 16'h1234; exp_add = 16'h8000;
`endif
    host_write(3'd0, 16'h1234);
    read_reg(3'd0, r);
    checks++; if (r !== exp_host) begin errors++; $display("FAIL zero_host got %h exp %h", r, exp_host); end
    host_write(3'd1, 16'h7FFF);
    host_write(3'd2, 16'h0001);
    prog[0] = 16'h202B;
    run_prog(dones, to);
    read_reg(3'd0, r);
    checks++; if (to || dones !== 1 || r !== exp_add || flags !== 6'h0C) begin errors++; $display("FAIL zero_add got to=%b dones=%0d r0=%h flags=%h exp 0 1 %h 0c", to, dones, r, flags, exp_add); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    @(negedge clk);
    test_reset;
    test_add_halt;
    test_carry_chain;
    test_fetch_stall;
    test_illegal;
    test_pc_wrap;
    test_reset_mid;
    test_zero_reg;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
